// File: rtl/booth_mul_pkg.sv
`default_nettype none
// ============================================================================
// booth_mul_pkg : shared types and constants for the radix-4 Booth sequencer
// Revision 1.0
// ============================================================================
package booth_mul_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int N_GROUPS = 8;
  localparam int FIELD_W  = OP_W + 1;
  localparam int GRP_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth group encodings {y[2i+1], y[2i], y[2i-1]}
  localparam logic [2:0] GRP_ZERO_A = 3'b000;
  localparam logic [2:0] GRP_P1_A   = 3'b001;
  localparam logic [2:0] GRP_P1_B   = 3'b010;
  localparam logic [2:0] GRP_P2     = 3'b011;
  localparam logic [2:0] GRP_M2     = 3'b100;
  localparam logic [2:0] GRP_M1_A   = 3'b101;
  localparam logic [2:0] GRP_M1_B   = 3'b110;
  localparam logic [2:0] GRP_ZERO_B = 3'b111;

endpackage
`default_nettype wire

// File: rtl/booth_decoder.sv
`default_nettype none
// ============================================================================
// booth_decoder : one radix-4 Booth group -> 17-bit field plus carry-in
// Revision 1.0
// ============================================================================
module booth_decoder
  import booth_mul_pkg::*;
(
  input  logic [OP_W-1:0]    x,
  input  logic [2:0]         grp_bits,
  output logic [FIELD_W-1:0] field,
  output logic               cin
);

  logic [FIELD_W-1:0] x_one;
  logic [FIELD_W-1:0] x_two;
  logic [FIELD_W-1:0] mag;
  logic               neg;

  assign x_one = {x[OP_W-1], x};
  assign x_two = {x, 1'b0};

  // Negation is split into complement here and +1 via cin in the adder.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (grp_bits)
      GRP_P1_A, GRP_P1_B: mag = x_one;
      GRP_P2:             mag = x_two;
      GRP_M2: begin
        mag = x_two;
        neg = 1'b1;
      end
      GRP_M1_A, GRP_M1_B: begin
        mag = x_one;
        neg = 1'b1;
      end
      default: begin
        mag = '0;
        neg = 1'b0;
      end
    endcase
    field = neg ? ~mag : mag;
    cin   = neg;
  end

endmodule
`default_nettype wire

// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
// booth_mul_seq : iterative 16x16 signed radix-4 Booth multiplier, 1 group/cycle
// Revision 1.0
// ============================================================================
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  state_t state;
  state_t state_nxt;

  logic [OP_W-1:0]    x_q;
  logic [OP_W-1:0]    y_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   tag_out_q;
  logic [PROD_W-1:0]  acc;
  logic [PROD_W-1:0]  p_q;
  logic [GRP_W-1:0]   grp;

  logic               accept;
  logic               last_grp;
  logic [OP_W:0]      y_ext;
  logic [2:0]         grp_bits;
  logic [4:0]         shamt;
  logic [FIELD_W-1:0] field;
  logic               cin;
  logic [PROD_W-1:0]  term;
  logic [PROD_W-1:0]  cin_term;
  logic [PROD_W-1:0]  acc_nxt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_p     = p_q;
  assign out_tag   = tag_out_q;

  assign accept   = in_valid && (state == IDLE);
  assign last_grp = (grp == GRP_W'(N_GROUPS - 1));

  // y_ext[j] = y[j-1] with y[-1] = 0, so group i sits at y_ext[2i +: 3].
  assign y_ext    = {y_q, 1'b0};
  assign grp_bits = y_ext[{grp, 1'b0} +: 3];
  assign shamt    = {1'b0, grp, 1'b0};

  booth_decoder u_dec (
    .x        (x_q),
    .grp_bits (grp_bits),
    .field    (field),
    .cin      (cin)
  );

  assign term     = {{(PROD_W - FIELD_W){field[FIELD_W-1]}}, field} << shamt;
  assign cin_term = {{(PROD_W - 1){1'b0}}, cin} << shamt;
  assign acc_nxt  = acc + term + cin_term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CALC;
      CALC:    if (last_grp) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result and tag get their own registers so they hold while the next op runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
      acc       <= '0;
      p_q       <= '0;
      grp       <= '0;
    end else begin
      if (accept) begin
        x_q   <= in_x;
        y_q   <= in_y;
        tag_q <= in_tag;
        acc   <= '0;
        grp   <= '0;
      end else if (state == CALC) begin
        acc <= acc_nxt;
        if (last_grp) begin
          p_q       <= acc_nxt;
          tag_out_q <= tag_q;
        end else begin
          grp <= grp + GRP_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_seq.sv
`default_nettype none
// ============================================================================
// tb_booth_mul_seq : directed self-checking bench for booth_mul_seq
// Revision 1.0
// ============================================================================
module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [3:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;

  booth_mul_seq #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Waits at most 40 cycles for out_valid; caller checks out_valid afterwards.
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_tag   = tag;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag,
                        input logic [31:0] exp, input string name);
    int n;
    issue(x, y, tag);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_lat"}, n, 32'd8);
    check({name, "_p"}, out_p, exp);
    check({name, "_tag"}, {28'd0, out_tag}, {28'd0, tag});
    @(negedge clk);
    check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_p", out_p, 32'd0);
    check("rst_tag", {28'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);

    run_op(16'd3, 16'd5, 4'h3, 32'h0000_000F, "m3x5");
    run_op(16'hFFFF, 16'h0001, 4'h1, 32'hFFFF_FFFF, "mneg1x1");
    run_op(16'h8000, 16'h8000, 4'h2, 32'h4000_0000, "mminxmin");
    run_op(16'h7FFF, 16'h8000, 4'h4, 32'hC000_8000, "mmaxxmin");
    run_op(16'h7FFF, 16'h7FFF, 4'h5, 32'h3FFF_0001, "mmaxxmax");
    run_op(16'h8000, 16'h0001, 4'h6, 32'hFFFF_8000, "mminx1");
    run_op(16'h0000, 16'h1234, 4'h7, 32'h0000_0000, "m0xk");
    run_op(16'hFFFB, 16'hFFF9, 4'h8, 32'h0000_0023, "mneg5xneg7");
    run_op(16'd1234, 16'hFFFF, 4'h9, 32'hFFFF_FB2E, "m1234xneg1");

    // Backpressure: five stalled cycles in DONE, handshake on the sixth.
    out_ready = 1'b0;
    issue(16'd100, 16'd100, 4'hA);
    wait_done(n);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_p", out_p, 32'h0000_2710);
      check("bp_hold_tag", {28'd0, out_tag}, 32'hA);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_p_held", out_p, 32'h0000_2710);
    check("bp_tag_held", {28'd0, out_tag}, 32'hA);

    // in_valid held through CALC with new operands: must wait for IDLE.
    issue(16'd6, 16'd7, 4'hB);
    in_valid = 1'b1;
    in_x     = 16'hFFFE;
    in_y     = 16'd9;
    in_tag   = 4'hC;
    repeat (3) @(negedge clk);
    check("hold_ready_calc", {31'd0, in_ready}, 32'd0);
    wait_done(n);
    check("hold_a_valid", {31'd0, out_valid}, 32'd1);
    check("hold_a_p", out_p, 32'h0000_002A);
    check("hold_a_tag", {28'd0, out_tag}, 32'hB);
    @(negedge clk);
    check("hold_idle_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("hold_b_valid", {31'd0, out_valid}, 32'd1);
    check("hold_b_lat", n, 32'd8);
    check("hold_b_p", out_p, 32'hFFFF_FFEE);
    check("hold_b_tag", {28'd0, out_tag}, 32'hC);
    @(negedge clk);

    // Reset at grp=4 aborts the operation.
    issue(16'h1234, 16'h0101, 4'hD);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_p", out_p, 32'd0);
    check("abort_tag", {28'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
    run_op(16'd7, 16'hFFF7, 4'hE, 32'hFFFF_FFC1, "m7xneg9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier sequencer. Accepts one signed 16×16 multiply through a valid/ready handshake. A single Booth group decoder is time-shared across the 8 operand groups, one group per cycle, and the partial products are accumulated into a 32-bit signed product. It is the area-reduced alternative to the fully parallel 8-decoder partial-product array and sits between the issue logic and the writeback stage.

## Interface
Parameters:
- TAG_W, default 4: width of the opaque tag carried from request to result.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE.
- in_x  in  16  multiplicand, two's complement.
- in_y  in  16  multiplier, two's complement; Booth-recoded.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_p  out  32  signed product in_x·in_y.
- out_tag  out  TAG_W  tag of the request that produced out_p.
- busy  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE → CALC → DONE → IDLE.
- **IDLE:** in_ready=1. When in_valid & in_ready:
  - latch x, y and tag;
  - acc←0, grp←0;
  - go to CALC.
- **CALC:** one group per cycle, grp = 0..7.
  - Group bits: {y[2·grp+1], y[2·grp], y[2·grp−1]}, with y[−1]=0.
  - Decode: 000/111 → 0; 001/010 → +x; 011 → +2x; 100 → −2x; 101/110 → −x.
  - Decoder output is a 17-bit magnitude field plus a carry-in bit `cin`. For negative selections the field is the bitwise complement and cin=1; otherwise cin=0.
  - Update: acc ← acc + (sext32(field17) << 2·grp) + (cin << 2·grp), modulo 2^32.
  - grp==7: perform the final add, then go to DONE. Otherwise grp increments.
- **DONE:** out_valid=1, out_p=acc, out_tag=latched tag, all held stable.
  - When out_ready=1: go to IDLE. The same cycle does not accept a new request.
- in_valid outside IDLE is ignored; the request stays pending upstream.
- out_p and out_tag hold their last values after handshake. Only out_valid qualifies them.
- No overflow is possible: every 16×16 signed product fits 32 bits. The modulo-2^32 wrap of intermediate sums is intended.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE;
  - in_ready=1 after reset is released;
  - out_valid=0, busy=0;
  - out_p=0, out_tag=0, acc=0, grp=0.
- Reset mid-CALC or mid-DONE aborts the operation; the result is discarded and never presented.
- Latency: the request is accepted at edge E0. CALC occupies edges E1..E8. out_valid rises after E8 and is visible in cycle 9.
- Back-to-back throughput: 1 operation per 10 cycles when out_ready is held high:
  - 1 accept cycle;
  - 8 CALC cycles;
  - 1 DONE cycle.
- out_ready low stalls in DONE indefinitely with no change to outputs.
- in_ready is combinational from state only; no path from in_valid.

## Structure
- Package booth_mul_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - OP_W=16, PROD_W=32, N_GROUPS=8;
  - the 3-bit Booth group encodings.
- Sub-module: one booth_decoder instance (16-bit x, 3-bit group in, 17-bit field plus cin out), driven by the latched x and the muxed group bits.
- The shift/accumulate adder, group counter and FSM live in the top module.

## Test plan
- 3×5 with out_ready=1: out_valid in cycle 9, out_p=0x0000000F, out_tag echoed; in_ready high again the cycle after the handshake.
- −1×1 → 0xFFFFFFFF. −32768×−32768 → 0x40000000. 32767×−32768 → 0xC0008000.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_p/out_tag/out_valid stable; handshake on the 6th cycle, then IDLE.
- in_valid held high with new operands during CALC → ignored; the second operation starts only after return to IDLE and completes with the correct product.
- rst_n=0 at grp=4 → next cycle all outputs at reset values; no out_valid pulse; a following 7×−9 yields 0xFFFFFFC1.
- Random 10k signed pairs versus a reference model, with random out_ready stalls: zero mismatches; each tag appears exactly once, in order.
